// File: rtl/dca_matrix_lsu_row_aligner.sv
// dca_matrix_lsu_row_aligner: registered store-side row aligner with per-bit write mask and overflow spill beat.
// Define DCA_ROW_ALIGNER_SPILL_EN to emit spill beats; otherwise overflow is dropped and flagged on spill_drop.
module dca_matrix_lsu_row_aligner #(
  parameter int BW_ROW            = 256,
  parameter int BW_OFFSET         = $clog2(BW_ROW),
  parameter int NUM_COL           = 16,
  parameter bit SUPPORT_MULTIBYTE = 1,
  parameter bit SUPPORT_SUBBYTE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW_ROW-1:0]    in_data,
  input  logic [NUM_COL-1:0]   in_col_mask,
  input  logic [2:0]           in_elem_log2,
  input  logic [BW_OFFSET-1:0] in_bit_offset,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW_ROW-1:0]    out_data,
  output logic [BW_ROW-1:0]    out_mask,
  output logic                 out_last,
  output logic                 out_spill,
  output logic                 spill_drop
);
  localparam int CW = NUM_COL > 1 ? $clog2(NUM_COL) : 1;
  localparam logic [BW_OFFSET-1:0] OFF_MSK = {{(BW_OFFSET-3){SUPPORT_MULTIBYTE}}, {3{SUPPORT_SUBBYTE}}};
`ifdef DCA_ROW_ALIGNER_SPILL_EN
  typedef enum logic [1:0] {EMPTY, MAIN, SPILL} state_t;
  logic [2*BW_ROW-1:0] dsh;
  logic [BW_ROW-1:0] dhi_q, dhi_d, mhi_q, mhi_d;
  logic lhi_q, lhi_d, pend_q, pend_d, spill_q, spill_d;
`else
  typedef enum logic {EMPTY, MAIN} state_t;
  logic [BW_ROW-1:0] dsh;
  logic drop_q, drop_d;
`endif
  state_t state_q, state_d;
  logic [2:0] e;
  logic [BW_OFFSET-1:0] off;
  logic [BW_ROW-1:0] m, data_q, data_d, mask_q, mask_d;
  logic [2*BW_ROW-1:0] msh;
  logic spill_needed, valid_q, valid_d, last_q, last_d, acc, hs;
  always_comb begin
    e = in_elem_log2 > 3'd5 ? 3'd5 : in_elem_log2;
    off = in_bit_offset & OFF_MSK;
    m = '0;
    for (int i = 0; i < BW_ROW; i++) m[i] = (i >> e) < NUM_COL ? in_col_mask[CW'(i >> e)] : 1'b0;
    msh = {{BW_ROW{1'b0}}, m} << off;
`ifdef DCA_ROW_ALIGNER_SPILL_EN
    dsh = {{BW_ROW{1'b0}}, in_data} << off;
`else
    dsh = in_data << off;
`endif
    spill_needed = |msh[2*BW_ROW-1:BW_ROW];
  end
`ifdef DCA_ROW_ALIGNER_SPILL_EN
  assign in_ready = state_q == EMPTY || (out_ready && (state_q == SPILL || (state_q == MAIN && !pend_q)));
  assign out_spill = spill_q;
  assign spill_drop = 1'b0;
`else
  assign in_ready = state_q == EMPTY || out_ready;
  assign out_spill = 1'b0;
  assign spill_drop = drop_q;
`endif
  assign acc = in_valid && in_ready;
  assign hs = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_mask = mask_q;
  assign out_last = last_q;
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d = data_q;
    mask_d = mask_q;
    last_d = last_q;
`ifdef DCA_ROW_ALIGNER_SPILL_EN
    dhi_d = dhi_q;
    mhi_d = mhi_q;
    lhi_d = lhi_q;
    pend_d = pend_q;
    spill_d = spill_q;
    if (state_q == MAIN && hs && pend_q) begin
      state_d = SPILL;
      data_d = dhi_q;
      mask_d = mhi_q;
      last_d = lhi_q;
      spill_d = 1'b1;
      pend_d = 1'b0;
    end else if (acc) begin
      state_d = MAIN;
      valid_d = 1'b1;
      data_d = dsh[BW_ROW-1:0];
      mask_d = msh[BW_ROW-1:0];
      last_d = in_last && !spill_needed;
      spill_d = 1'b0;
      pend_d = spill_needed;
      dhi_d = dsh[2*BW_ROW-1:BW_ROW];
      mhi_d = msh[2*BW_ROW-1:BW_ROW];
      lhi_d = in_last;
    end else if (hs) begin
      state_d = EMPTY;
      valid_d = 1'b0;
    end
`else
    drop_d = 1'b0;
    if (acc) begin
      state_d = MAIN;
      valid_d = 1'b1;
      data_d = dsh;
      mask_d = msh[BW_ROW-1:0];
      last_d = in_last;
      drop_d = spill_needed;
    end else if (hs) begin
      state_d = EMPTY;
      valid_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
`ifdef DCA_ROW_ALIGNER_SPILL_EN
      dhi_q <= '0;
      mhi_q <= '0;
      lhi_q <= 1'b0;
      pend_q <= 1'b0;
      spill_q <= 1'b0;
`else
      drop_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q <= data_d;
      mask_q <= mask_d;
      last_q <= last_d;
`ifdef DCA_ROW_ALIGNER_SPILL_EN
      dhi_q <= dhi_d;
      mhi_q <= mhi_d;
      lhi_q <= lhi_d;
      pend_q <= pend_d;
      spill_q <= spill_d;
`else
      drop_q <= drop_d;
`endif
    end
  end
endmodule

// File: tb/tb_dca_matrix_lsu_row_aligner.sv
// tb_dca_matrix_lsu_row_aligner: scoreboard bench for the row aligner, directed cases then random traffic.
module tb_dca_matrix_lsu_row_aligner;
  localparam int BW = 256;
  localparam int OW = 8;
  localparam int NC = 16;
`ifdef DCA_ROW_ALIGNER_SPILL_EN
  localparam bit SPILL_ON = 1'b1;
`else
  localparam bit SPILL_ON = 1'b0;
`endif
  typedef struct {
    logic [BW-1:0] d;
    logic [BW-1:0] m;
    logic l;
    logic s;
    logic drop;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, out_spill, spill_drop;
  logic [BW-1:0] in_data, out_data, out_mask;
  logic [NC-1:0] in_col_mask;
  logic [2:0] in_elem_log2;
  logic [OW-1:0] in_bit_offset;
  logic v2, rdy2, ov2, last2, spill2, drop2, ordy2;
  logic [BW-1:0] data2, mask2;
  beat_t q[$];
  int n_chk = 0, n_pass = 0;
  logic stall = 1'b0;
  logic [BW-1:0] h_d, h_m, s_mask, exp_v;
  logic s_rdy, s_ov, s_last, s_spill;
  always #5 clk = ~clk;
  dca_matrix_lsu_row_aligner #(.BW_ROW(BW), .NUM_COL(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_col_mask(in_col_mask), .in_elem_log2(in_elem_log2), .in_bit_offset(in_bit_offset),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_last(out_last), .out_spill(out_spill), .spill_drop(spill_drop)
  );
  dca_matrix_lsu_row_aligner #(.BW_ROW(BW), .NUM_COL(NC), .SUPPORT_SUBBYTE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(in_data),
    .in_col_mask(in_col_mask), .in_elem_log2(in_elem_log2), .in_bit_offset(in_bit_offset),
    .in_last(in_last), .out_valid(ov2), .out_ready(ordy2), .out_data(data2),
    .out_mask(mask2), .out_last(last2), .out_spill(spill2), .spill_drop(drop2)
  );
  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic push_row();
    int w, o;
    logic [2*BW-1:0] mm, dd;
    logic sn;
    w = 1 << ((in_elem_log2 > 3'd5) ? 5 : int'(in_elem_log2));
    mm = '0;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < w; k++)
        if (c * w + k < BW) mm[c*w+k] = in_col_mask[c];
    o = int'(in_bit_offset);
    mm = mm << o;
    dd = {{BW{1'b0}}, in_data} << o;
    sn = |mm[2*BW-1:BW];
    if (SPILL_ON) begin
      q.push_back('{dd[BW-1:0], mm[BW-1:0], in_last && !sn, 1'b0, 1'b0});
      if (sn) q.push_back('{dd[2*BW-1:BW], mm[2*BW-1:BW], in_last, 1'b1, 1'b0});
    end else q.push_back('{dd[BW-1:0], mm[BW-1:0], in_last, 1'b0, sn});
  endtask
  task automatic step();
    #1;
    s_rdy = in_ready;
    s_ov = out_valid;
    s_mask = out_mask;
    s_last = out_last;
    s_spill = out_spill;
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (stall) begin
          chk("hold_data", out_data, h_d);
          chk("hold_mask", out_mask, h_m);
        end
        if (q.size() == 0) chk("unexpected_beat", out_valid, 0);
        else begin
          chk("data", out_data, q[0].d);
          chk("mask", out_mask, q[0].m);
          chk("last", out_last, q[0].l);
          chk("spill", out_spill, q[0].s);
          chk("spill_drop", spill_drop, stall ? 1'b0 : q[0].drop);
          if (out_ready) void'(q.pop_front());
        end
        stall = !out_ready;
        h_d = out_data;
        h_m = out_mask;
      end else begin
        chk("idle_drop", spill_drop, 0);
        stall = 1'b0;
      end
      if (in_valid && in_ready) push_row();
    end
    @(negedge clk);
  endtask
  task automatic set_row(input int off, input int e, input logic [NC-1:0] cm, input logic last);
    in_bit_offset = OW'(off);
    in_elem_log2 = 3'(e);
    in_col_mask = cm;
    in_last = last;
    for (int i = 0; i < BW / 32; i++) in_data[i*32+:32] = $urandom;
  endtask
  initial begin
    in_valid = 0; out_ready = 1; v2 = 0; ordy2 = 1;
    set_row(0, 0, '0, 0);
    @(negedge clk);
    repeat (2) step();
    rst = 0;
    step();
    chk("rst_valid", s_ov, 0);
    chk("rst_ready", s_rdy, 1);
    chk("rst_data", out_data, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_last", out_last, 0);
    chk("rst_spill", out_spill, 0);
    chk("rst_drop", spill_drop, 0);
    set_row(0, 3, 16'hFFFF, 1); in_valid = 1;
    step();
    chk("aligned_acc", s_rdy, 1);
    in_valid = 0;
    step();
    exp_v = {{128{1'b0}}, {128{1'b1}}};
    chk("aligned_lat", s_ov, 1);
    chk("aligned_mask", s_mask, exp_v);
    chk("aligned_last", s_last, 1);
    chk("aligned_spill", s_spill, 0);
    step();
    chk("aligned_single", s_ov, 0);
    set_row(200, 3, 16'hFFFF, 1); in_valid = 1;
    step();
    in_valid = 0;
    step();
    exp_v = {{56{1'b1}}, {200{1'b0}}};
    chk("spill_main_rdy", s_rdy, !SPILL_ON);
    chk("spill_main_mask", s_mask, exp_v);
    chk("spill_main_last", s_last, !SPILL_ON);
    step();
    exp_v = {{184{1'b0}}, {72{1'b1}}};
    chk("spill_beat_valid", s_ov, SPILL_ON);
    chk("spill_beat_flag", s_spill, SPILL_ON);
    chk("spill_beat_mask", s_mask & {BW{s_ov}}, SPILL_ON ? exp_v : '0);
    step();
    for (int i = 0; i < 8; i++) begin
      set_row(0, $urandom_range(0, 7), NC'($urandom), i == 7); in_valid = 1;
      step();
      chk("b2b_ready", s_rdy, 1);
      if (i > 0) chk("b2b_valid", s_ov, 1);
    end
    in_valid = 0;
    step();
    chk("b2b_tail", s_ov, 1);
    step();
    set_row(200, 3, 16'hFFFF, 0); in_valid = 1;
    step();
    in_valid = 0; out_ready = 0;
    repeat (5) step();
    out_ready = 1;
    step();
    step();
    chk("bp_spill_next", s_spill, SPILL_ON);
    step();
    set_row(5, 0, 16'h0001, 1); in_valid = 1; v2 = 1;
    step();
    in_valid = 0; v2 = 0;
    chk("sub0_valid", ov2, 1);
    chk("sub0_mask", mask2, 1);
    step();
    chk("sub1_mask", s_mask, 256'h20);
    step();
    set_row(200, 3, 16'hFFFF, 1); in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst_spill_valid", s_ov, 0);
    repeat (3) step();
    for (int i = 0; i < 300; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      set_row($urandom_range(0, 255), $urandom_range(0, 7), NC'($urandom), $urandom_range(0, 1) == 1);
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain", BW'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
